// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control/status bundle between a divider client and clk_div_prog
interface clk_div_prog_if #(
    parameter int W = 8
);
    logic         en;
    logic         load;
    logic [W-1:0] div_in;
    logic [W-1:0] duty_in;
    logic         mode_in;
    logic         clk_out;
    logic         tick;
    logic         load_ack;
    logic         cfg_err;
    modport master (
        output en, load, div_in, duty_in, mode_in,
        input  clk_out, tick, load_ack, cfg_err
    );
    modport slave (
        input  en, load, div_in, duty_in, mode_in,
        output clk_out, tick, load_ack, cfg_err
    );
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable glitch-free divider with duty control and pulse mode
module clk_div_prog #(
    parameter int W        = 8,
    parameter int DEF_DIV  = 10,
    parameter bit DEF_MODE = 1'b0
) (
    input logic           clk,
    input logic           rst,
    clk_div_prog_if.slave bus
);
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] TWO = W'(2);
    logic [W-1:0] r_cnt, r_div, r_h, r_pd, r_ph;
    logic         r_mode, r_pm, r_pend, r_inst, r_out, r_tick, r_ack, r_err;
    logic         w_last, w_bad, w_ok, w_pend, w_inst, w_mode, w_pm;
    logic [W-1:0] w_cnt_nx, w_h_req, w_pd, w_ph, w_h;
    // next count, request validation, and the config that governs the coming edge
    always_comb begin
        w_last   = r_cnt == r_div - ONE;
        w_cnt_nx = w_last ? '0 : r_cnt + ONE;
        w_bad    = bus.load && bus.div_in < TWO;
        w_ok     = bus.load && !w_bad;
        w_h_req  = bus.duty_in == '0 ? bus.div_in >> 1 :
                   bus.duty_in >= bus.div_in ? bus.div_in - ONE : bus.duty_in;
        w_pd     = w_ok ? bus.div_in : r_pd;
        w_ph     = w_ok ? w_h_req : r_ph;
        w_pm     = w_ok ? bus.mode_in : r_pm;
        w_pend   = w_ok || r_pend;
        w_inst   = w_pend && (w_last || !bus.en);
        w_h      = w_inst ? w_ph : r_h;
        w_mode   = w_inst ? w_pm : r_mode;
    end
    // counter, outputs and config install; a new config only lands on a period boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_div  <= W'(DEF_DIV);
            r_h    <= W'(DEF_DIV / 2);
            r_mode <= DEF_MODE;
            r_pend <= 1'b0;
            r_pd   <= '0;
            r_ph   <= '0;
            r_pm   <= 1'b0;
            r_inst <= 1'b0;
            r_out  <= 1'b0;
            r_tick <= 1'b0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err  <= w_bad;
            r_ack  <= r_inst;
            r_inst <= w_inst;
            r_pend <= w_pend && !w_inst;
            r_pd   <= w_pd;
            r_ph   <= w_ph;
            r_pm   <= w_pm;
            if (w_inst) begin
                r_div  <= w_pd;
                r_h    <= w_ph;
                r_mode <= w_pm;
            end
            if (bus.en) begin
                r_cnt  <= w_cnt_nx;
                r_tick <= w_last;
                r_out  <= w_mode ? w_last : (w_cnt_nx < w_h);
            end else begin
                r_tick <= 1'b0;
                if (w_inst) begin
                    r_cnt <= '0;
                    r_out <= 1'b0;
                end
            end
        end
    end
    assign bus.clk_out  = r_out;
    assign bus.tick     = r_tick;
    assign bus.load_ack = r_ack;
    assign bus.cfg_err  = r_err;
endmodule
